mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, giving the memory depth in words as 2^ADDR_W.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, giving the wait states inserted before each response (range 0..15).
REQ-003 The block SHALL have port Clk1, input, 1 bit: the clock; reset Reset, synchronous, active-high; clock Clk1.
REQ-004 The block SHALL have port Reset, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have port Addr, input, 16 bits: word address from the processor.
REQ-006 The block SHALL have port RD, input, 1 bit: read request level.
REQ-007 The block SHALL have port WR, input, 1 bit: write request level.
REQ-008 The block SHALL have port WData, input, 16 bits: write data from the processor's DataOut.
REQ-009 The block SHALL have port Burst, input, 1 bit: marks a read request as a 16-word vector burst.
REQ-010 The block SHALL have port RData, output, 16 bits: read data to the processor's DataIn.
REQ-011 The block SHALL have port Ready, output, 1 bit: one-cycle strobe marking each completed word.
REQ-012 The block SHALL have port Busy, output, 1 bit: high while a request is in progress.
REQ-013 The block SHALL have port Err, output, 1 bit: one-cycle strobe marking a rejected or faulted request.

Function
REQ-014 The FSM SHALL have the states IDLE, WAIT, XFER and BURST.
REQ-015 A request SHALL be accepted only in IDLE, on a rising edge of RD or WR (low in the previous Clk1 cycle, high now); a held level SHALL NOT retrigger.
REQ-016 On acceptance, the block SHALL capture Addr, WData, request type and Burst, set Busy=1, load the wait counter with WAIT_CYCLES, and go to WAIT.
REQ-017 WAIT SHALL decrement the counter each cycle and go to XFER when the counter is 0; with WAIT_CYCLES=0, WAIT lasts exactly 1 cycle.
REQ-018 For a read in XFER, RData SHALL be mem[captured addr] and Ready=1 for that cycle.
REQ-019 For a write in XFER, mem[captured addr] SHALL be written with the captured data at the end of that cycle and Ready=1 for that cycle.
REQ-020 After XFER the block SHALL return to IDLE with Busy=0, unless a burst is active.
REQ-021 Latency from the accepting edge to Ready SHALL be WAIT_CYCLES+2 cycles.
REQ-022 RData SHALL hold its last value between reads.
REQ-023 Simultaneous RD and WR rising edges SHALL produce no memory access, Err=1 for one cycle, and the block SHALL stay in IDLE.
REQ-024 An address with Addr[15:ADDR_W] nonzero SHALL complete with normal timing; a read returns 0x0000, a write is discarded, and Err=1 in the same cycle as Ready.
REQ-025 RD or WR edges while Busy=1 SHALL be ignored silently, with no Err.
REQ-026 Memory contents SHALL be uninitialised at power-up and SHALL NOT be cleared by Reset.

Reset
REQ-027 Reset SHALL force IDLE, RData=0x0000, Ready=0, Busy=0, Err=0, wait counter=0, burst counter=0, and clear the edge-detect history to 0.
REQ-028 Reset asserted mid-request SHALL abort it: no pending write is committed and no Ready is issued.
REQ-029 The first request after Reset deasserts SHALL require a fresh rising edge.

Configuration
REQ-030 With macro MEM_RESPONDER_BURST_EN defined, a read accepted with Burst=1 SHALL, after WAIT, enter BURST and return 16 words at consecutive cycles.
REQ-031 Burst word i SHALL be mem[(base+i) mod 2^ADDR_W] with Ready=1 on each word, then the block returns to IDLE.
REQ-032 Out-of-range checking for a burst SHALL be performed once, on the base address.
REQ-033 With MEM_RESPONDER_BURST_EN undefined, Burst SHALL be ignored, every read SHALL be single-word, and the BURST state SHALL be absent.
REQ-034 Burst SHALL always be ignored on writes.

Verification
REQ-035 Write 0xBEEF to 0x0005, then read 0x0005 with WAIT_CYCLES=2 -> Ready 4 cycles after each edge, and RData=0xBEEF.
REQ-036 RD held high for 10 cycles -> exactly one Ready; a second RD edge during Busy -> ignored, with no Err.
REQ-037 RD and WR rising together -> Err pulse, memory unchanged, Busy stays 0; read of 0x0400 with ADDR_W=10 -> RData=0x0000 with Err and Ready together.
REQ-038 Reset asserted during WAIT of a write of 0x1234 to 0x0010 -> no Ready, and a later read of 0x0010 returns the prior value.
REQ-039 With BURST_EN, preload mem[0x3F8..0x3FF] and mem[0x000..0x007] with the values 0..15, then burst read base 0x3F8 -> 16 consecutive Ready cycles returning 0..15 with wrap; with the macro undefined -> a single Ready returning 0.

Source files
------------

// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
// Processor-side memory bus between a processor (master) and mem_responder
// (slave).
//   Addr  [15:0] word address               master -> slave
//   RD           read request level         master -> slave
//   WR           write request level        master -> slave
//   WData [15:0] write data                 master -> slave
//   Burst        read is a 16-word burst    master -> slave
//   RData [15:0] read data                  slave  -> master
//   Ready        one-cycle completed-word   slave  -> master
//   Busy         request in progress        slave  -> master
//   Err          one-cycle rejected/fault   slave  -> master
// -----------------------------------------------------------------------------
interface mem_responder_if;
   logic [15:0] Addr;
   logic        RD;
   logic        WR;
   logic [15:0] WData;
   logic        Burst;
   logic [15:0] RData;
   logic        Ready;
   logic        Busy;
   logic        Err;

   modport master (
      output Addr, RD, WR, WData, Burst,
      input  RData, Ready, Busy, Err
   );

   modport slave (
      input  Addr, RD, WR, WData, Burst,
      output RData, Ready, Busy, Err
   );
endinterface

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Word-addressed memory that answers RD/WR request edges from a processor
// after WAIT_CYCLES wait states. Outputs are registered, so Ready arrives
// WAIT_CYCLES+2 cycles after the accepting clock edge.
//
// Parameters
//   ADDR_W      memory depth is 2**ADDR_W words (ADDR_W < 16)
//   WAIT_CYCLES wait states before each response (0..15)
// Ports
//   Clk1        clock
//   Reset       synchronous, active-high reset
//   io_Bus      mem_responder_if.slave (Addr, RD, WR, WData, Burst,
//               RData, Ready, Busy, Err)
// Configuration
//   MEM_RESPONDER_BURST_EN  when defined, a read with Burst=1 returns 16
//                           consecutive words (address wraps mod depth).
// -----------------------------------------------------------------------------
module mem_responder #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 2
) (
   input logic             Clk1,
   input logic             Reset,
   mem_responder_if.slave  io_Bus
);

`ifdef MEM_RESPONDER_BURST_EN
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, XFER = 2'd2, BURST = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, XFER = 2'd2} state_t;
`endif

   // Memory is deliberately left without reset so it maps onto RAM.
   logic [15:0]       r_Mem [2**ADDR_W];

   state_t            r_State;
   state_t            w_NextState;

   logic              r_RdPrev;
   logic              r_WrPrev;
   // History is only trusted after one post-reset sample, so a level held
   // through Reset is not mistaken for a fresh edge.
   logic              r_HistValid;

   logic [15:0]       r_Addr;
   logic [15:0]       r_WData;
   logic              r_IsWrite;
   logic [3:0]        r_WaitCnt;
   logic [3:0]        r_BurstCnt;

   logic [15:0]       r_RData;
   logic              r_Ready;
   logic              r_Busy;
   logic              r_Err;

   logic              w_RdRise;
   logic              w_WrRise;
   logic              w_Accept;
   logic              w_OutOfRange;
   logic [ADDR_W-1:0] w_ReadIdx;
   logic [15:0]       w_RDataNext;
   logic              w_ReadyNext;
   logic              w_ErrNext;
   logic              w_MemWe;

`ifdef MEM_RESPONDER_BURST_EN
   logic              r_Burst;
`else
   logic              w_unused_burst;
   assign w_unused_burst = io_Bus.Burst;
`endif

   assign w_RdRise     = io_Bus.RD & ~r_RdPrev & r_HistValid;
   assign w_WrRise     = io_Bus.WR & ~r_WrPrev & r_HistValid;
   // Exactly one request type; simultaneous edges are rejected.
   assign w_Accept     = w_RdRise ^ w_WrRise;
   assign w_OutOfRange = (r_Addr >> ADDR_W) != 16'd0;
   // Burst counter stays 0 outside BURST, so single reads share this index.
   assign w_ReadIdx    = r_Addr[ADDR_W-1:0] + ADDR_W'(r_BurstCnt);

   // State and datapath registers
   always_ff @(posedge Clk1) begin
      if (Reset) begin
         r_State     <= IDLE;
         r_RdPrev    <= 1'b0;
         r_WrPrev    <= 1'b0;
         r_HistValid <= 1'b0;
         r_Addr      <= 16'h0000;
         r_WData     <= 16'h0000;
         r_IsWrite   <= 1'b0;
         r_WaitCnt   <= 4'd0;
         r_BurstCnt  <= 4'd0;
         r_RData     <= 16'h0000;
         r_Ready     <= 1'b0;
         r_Busy      <= 1'b0;
         r_Err       <= 1'b0;
`ifdef MEM_RESPONDER_BURST_EN
         r_Burst     <= 1'b0;
`endif
      end else begin
         r_State     <= w_NextState;
         r_RdPrev    <= io_Bus.RD;
         r_WrPrev    <= io_Bus.WR;
         r_HistValid <= 1'b1;
         r_RData     <= w_RDataNext;
         r_Ready     <= w_ReadyNext;
         r_Err       <= w_ErrNext;
         r_Busy      <= (w_NextState != IDLE);

         if (r_State == IDLE && w_Accept) begin
            r_Addr    <= io_Bus.Addr;
            r_WData   <= io_Bus.WData;
            r_IsWrite <= w_WrRise;
            r_WaitCnt <= 4'(WAIT_CYCLES);
`ifdef MEM_RESPONDER_BURST_EN
            r_Burst   <= io_Bus.Burst & w_RdRise;
`endif
         end else if (r_State == WAIT && r_WaitCnt != 4'd0) begin
            r_WaitCnt <= r_WaitCnt - 4'd1;
         end

`ifdef MEM_RESPONDER_BURST_EN
         // Wraps back to 0 after the 16th word.
         if (r_State == BURST) begin
            r_BurstCnt <= r_BurstCnt + 4'd1;
         end
`endif
      end
   end

   // Write commits at the end of XFER; an asserted Reset aborts it.
   always_ff @(posedge Clk1) begin
      if (w_MemWe && !Reset) begin
         r_Mem[r_Addr[ADDR_W-1:0]] <= r_WData;
      end
   end

   // Next-state logic
   always_comb begin
      w_NextState = r_State;
      case (r_State)
         IDLE: begin
            if (w_Accept) w_NextState = WAIT;
         end
         WAIT: begin
            if (r_WaitCnt == 4'd0) begin
`ifdef MEM_RESPONDER_BURST_EN
               w_NextState = (r_Burst && !r_IsWrite) ? BURST : XFER;
`else
               w_NextState = XFER;
`endif
            end
         end
         XFER: w_NextState = IDLE;
`ifdef MEM_RESPONDER_BURST_EN
         BURST: begin
            if (r_BurstCnt == 4'd15) w_NextState = IDLE;
         end
`endif
         default: w_NextState = IDLE;
      endcase
   end

   // Output logic (values registered on the following edge)
   always_comb begin
      w_RDataNext = r_RData;
      w_ReadyNext = 1'b0;
      w_ErrNext   = 1'b0;
      w_MemWe     = 1'b0;
      case (r_State)
         IDLE: begin
            w_ErrNext = w_RdRise & w_WrRise;
         end
         XFER: begin
            w_ReadyNext = 1'b1;
            w_ErrNext   = w_OutOfRange;
            if (r_IsWrite) begin
               w_MemWe = !w_OutOfRange;
            end else begin
               w_RDataNext = w_OutOfRange ? 16'h0000 : r_Mem[w_ReadIdx];
            end
         end
`ifdef MEM_RESPONDER_BURST_EN
         BURST: begin
            // Range is judged once on the base; Err rides with the first word.
            w_ReadyNext = 1'b1;
            w_ErrNext   = w_OutOfRange && (r_BurstCnt == 4'd0);
            w_RDataNext = w_OutOfRange ? 16'h0000 : r_Mem[w_ReadIdx];
         end
`endif
         default: ;
      endcase
   end

   assign io_Bus.RData = r_RData;
   assign io_Bus.Ready = r_Ready;
   assign io_Bus.Busy  = r_Busy;
   assign io_Bus.Err   = r_Err;

endmodule
